// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: reset PC, NOP word, opcodes, branch encodings,
// the IF/ID register payload and small address helpers.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_BEQ           = 6'b000100;
    localparam logic [5:0]  OP_BNE           = 6'b000101;

    // Branch kind encodings shared with the decoder.
    typedef enum logic [1:0] {
        BRANCH_NONE = 2'b00,
        BRANCH_EQ   = 2'b01,
        BRANCH_NE   = 2'b10,
        BRANCH_JUMP = 2'b11
    } branch_e;

    typedef enum logic [1:0] {
        PC_SEL_HOLD   = 2'b00,
        PC_SEL_JUMP   = 2'b01,
        PC_SEL_BRANCH = 2'b10,
        PC_SEL_SEQ    = 2'b11
    } pc_sel_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_WORD, pc_plus4: 32'h0000_0000, valid: 1'b0};

    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] index);
        return {pc_hi, index, 2'b00};
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: enable holds, clear inserts a bubble, hold beats clear.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out
);

    if_id_t id_d;
    if_id_t id_q;

    // Next IF/ID contents: hold, bubble, or capture the fetched word.
    always_comb begin
        id_d = id_q;
        if (!en) begin
            id_d = id_q;
        end else if (clr) begin
            id_d = IF_ID_BUBBLE;
        end else begin
            id_d.instr    = instr_in;
            id_d.pc_plus4 = pc_plus4_in;
            id_d.valid    = 1'b1;
        end
    end

    // IF/ID state register with asynchronous reset to a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= IF_ID_BUBBLE;
        end else begin
            id_q <= id_d;
        end
    end

    assign instr_out    = id_q.instr;
    assign pc_plus4_out = id_q.pc_plus4;
    assign valid_out    = id_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_f;
    logic [31:0] jump_tgt_d;
    logic [31:0] branch_tgt_d;
    pc_sel_e     pc_sel;

    // Next-PC selection; a redirect during StallF is dropped because decode repeats it.
    always_comb begin
        pc_plus4_f   = pc_q + PC_INCR;
        jump_tgt_d   = jump_target(PCPlus4D[31:28], InstrD[25:0]);
        branch_tgt_d = word_align(PCBranchD);
        pc_sel       = PC_SEL_SEQ;
        pc_d         = pc_plus4_f;
        if (StallF) begin
            pc_sel = PC_SEL_HOLD;
        end else if (JumpD) begin
            pc_sel = PC_SEL_JUMP;
        end else if (PCSrcD) begin
            pc_sel = PC_SEL_BRANCH;
        end else begin
            pc_sel = PC_SEL_SEQ;
        end
        case (pc_sel)
            PC_SEL_HOLD:   pc_d = pc_q;
            PC_SEL_JUMP:   pc_d = jump_tgt_d;
            PC_SEL_BRANCH: pc_d = branch_tgt_d;
            PC_SEL_SEQ:    pc_d = pc_plus4_f;
            default:       pc_d = pc_plus4_f;
        endcase
    end

    // PC register with asynchronous reset to the boot address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PCF       = pc_q;
    assign imem_addr = pc_q;

    fetch_stage_if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst          (reset),
        .en           (~StallD),
        .clr          (FlushD),
        .instr_in     (imem_rdata),
        .pc_plus4_in  (pc_plus4_f),
        .instr_out    (InstrD),
        .pc_plus4_out (PCPlus4D),
        .valid_out    (ValidD)
    );

endmodule
